// File: rtl/tick_sched.sv
// Tick scheduler: divides a shared base tick into per-channel periodic events and
// serialises them onto a one-hot fire output with round-robin arbitration.
//
// Ports:
//   clk, reset      - clock and synchronous active-high reset
//   base_tick       - one-cycle base event from the feeding tick generator
//   tick_en         - registered enable for the tick generator (OR of active channels)
//   cfg_we/cfg_ch/cfg_period - per-channel period write; period 0 disables the channel
//   ovr_clr         - clears all sticky overrun flags
//   fire/fire_valid/fire_ch  - registered one-cycle grant pulse for one channel
//   overrun         - sticky per-channel "event lost" flags
module tick_sched #(
  parameter int unsigned NCH = 4,
  parameter int unsigned PW  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    base_tick,
  output logic                    tick_en,
  input  logic                    cfg_we,
  input  logic [$clog2(NCH)-1:0]  cfg_ch,
  input  logic [PW-1:0]           cfg_period,
  input  logic                    ovr_clr,
  output logic [NCH-1:0]          fire,
  output logic                    fire_valid,
  output logic [$clog2(NCH)-1:0]  fire_ch,
  output logic [NCH-1:0]          overrun
);

  localparam int unsigned CW = $clog2(NCH);

  logic [PW-1:0]  per_q [NCH];
  logic [PW-1:0]  per_d [NCH];
  logic [PW-1:0]  cnt_q [NCH];
  logic [PW-1:0]  cnt_d [NCH];
  logic [NCH-1:0] act_q, act_d;
  logic [NCH-1:0] pend_q, pend_d;
  logic [NCH-1:0] ovr_q, ovr_d;
  logic [CW-1:0]  ptr_q, ptr_d;
  logic [NCH-1:0] fire_q, fire_d;
  logic           fire_valid_q, fire_valid_d;
  logic [CW-1:0]  fire_ch_q, fire_ch_d;
  logic           tick_en_q, tick_en_d;

  logic [NCH-1:0] due;
  logic           grant_valid;
  logic [CW-1:0]  grant_idx;
  logic [CW-1:0]  cand;

  // Round-robin search over pre-edge pending bits, starting at ptr_q.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      cand = CW'((32'(ptr_q) + i) % NCH);
      if (!grant_valid && pend_q[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    due    = '0;
    act_d  = act_q;
    pend_d = pend_q;
    ovr_d  = ovr_q;
    for (int unsigned n = 0; n < NCH; n++) begin
      per_d[n] = per_q[n];
      cnt_d[n] = cnt_q[n];
    end

    for (int unsigned n = 0; n < NCH; n++) begin
      // A write to a channel masks that channel's base tick in the same cycle.
      if (cfg_we && (cfg_ch == CW'(n))) begin
        if (cfg_period != '0) begin
          per_d[n] = cfg_period;
          cnt_d[n] = cfg_period;
          act_d[n] = 1'b1;
        end else begin
          act_d[n] = 1'b0;
        end
        pend_d[n] = 1'b0;
      end else begin
        if (base_tick && act_q[n]) begin
          if (cnt_q[n] == PW'(1)) begin
            due[n]   = 1'b1;
            cnt_d[n] = per_q[n];
          end else begin
            cnt_d[n] = cnt_q[n] - PW'(1);
          end
        end
        // A due on the granted channel keeps it pending: the new event is not lost.
        if (due[n]) begin
          pend_d[n] = 1'b1;
        end else if (grant_valid && (grant_idx == CW'(n))) begin
          pend_d[n] = 1'b0;
        end
      end

      // Overrun set takes priority over the clear.
      if (due[n] && pend_q[n] && !(grant_valid && (grant_idx == CW'(n)))) begin
        ovr_d[n] = 1'b1;
      end else if (ovr_clr) begin
        ovr_d[n] = 1'b0;
      end
    end
  end

  always_comb begin
    fire_d       = '0;
    fire_valid_d = grant_valid;
    fire_ch_d    = '0;
    ptr_d        = ptr_q;
    tick_en_d    = |act_q;
    if (grant_valid) begin
      fire_d    = NCH'(1) << grant_idx;
      fire_ch_d = grant_idx;
      ptr_d     = (grant_idx == CW'(NCH - 1)) ? '0 : grant_idx + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned n = 0; n < NCH; n++) begin
        per_q[n] <= '0;
        cnt_q[n] <= '0;
      end
      act_q        <= '0;
      pend_q       <= '0;
      ovr_q        <= '0;
      ptr_q        <= '0;
      fire_q       <= '0;
      fire_valid_q <= 1'b0;
      fire_ch_q    <= '0;
      tick_en_q    <= 1'b0;
    end else begin
      for (int unsigned n = 0; n < NCH; n++) begin
        per_q[n] <= per_d[n];
        cnt_q[n] <= cnt_d[n];
      end
      act_q        <= act_d;
      pend_q       <= pend_d;
      ovr_q        <= ovr_d;
      ptr_q        <= ptr_d;
      fire_q       <= fire_d;
      fire_valid_q <= fire_valid_d;
      fire_ch_q    <= fire_ch_d;
      tick_en_q    <= tick_en_d;
    end
  end

  assign tick_en    = tick_en_q;
  assign fire       = fire_q;
  assign fire_valid = fire_valid_q;
  assign fire_ch    = fire_ch_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_tick_sched.sv
// Self-checking bench for tick_sched (NCH=4, PW=8): directed scenarios with literal
// expectations plus randomized traffic, all compared every cycle against a model that
// tracks ticks seen since each write and serves pending events in round-robin order.
module tb_tick_sched;

  localparam int NCH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       base_tick = 1'b0;
  logic       tick_en;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_ch = '0;
  logic [7:0] cfg_period = '0;
  logic       ovr_clr = 1'b0;
  logic [3:0] fire;
  logic       fire_valid;
  logic [1:0] fire_ch;
  logic [3:0] overrun;

  tick_sched #(.NCH(4), .PW(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .base_tick  (base_tick),
    .tick_en    (tick_en),
    .cfg_we     (cfg_we),
    .cfg_ch     (cfg_ch),
    .cfg_period (cfg_period),
    .ovr_clr    (ovr_clr),
    .fire       (fire),
    .fire_valid (fire_valid),
    .fire_ch    (fire_ch),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int fires_by_ch [NCH];

  // Behavioural model: period, ticks seen since the write, and event flags.
  int m_per  [NCH];
  int m_seen [NCH];
  bit m_act  [NCH];
  bit m_pend [NCH];
  bit m_ovr  [NCH];
  int m_ptr;
  bit m_fv;
  int m_fc;
  bit m_te;

  task automatic chk(input string name, input int actual, input int expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic model_update();
    int g;
    bit any_act;
    bit due;
    bit wr;
    g = -1;
    if (reset) begin
      for (int n = 0; n < NCH; n++) begin
        m_per[n] = 0; m_seen[n] = 0; m_act[n] = 0; m_pend[n] = 0; m_ovr[n] = 0;
      end
      m_ptr = 0; m_fv = 0; m_fc = 0; m_te = 0;
      return;
    end
    any_act = 0;
    for (int i = 0; i < NCH; i++) begin
      if (g < 0 && m_pend[(m_ptr + i) % NCH]) g = (m_ptr + i) % NCH;
      if (m_act[i]) any_act = 1;
    end
    for (int n = 0; n < NCH; n++) begin
      wr  = cfg_we && (int'(cfg_ch) == n);
      due = 0;
      if (wr) begin
        if (cfg_period != 0) begin
          m_per[n] = int'(cfg_period); m_seen[n] = 0; m_act[n] = 1;
        end else begin
          m_act[n] = 0;
        end
      end else if (base_tick && m_act[n]) begin
        m_seen[n]++;
        due = (m_seen[n] % m_per[n]) == 0;
      end
      if (due && m_pend[n] && g != n) m_ovr[n] = 1;
      else if (ovr_clr) m_ovr[n] = 0;
      if (wr) m_pend[n] = 0;
      else if (due) m_pend[n] = 1;
      else if (g == n) m_pend[n] = 0;
    end
    m_te = any_act;
    m_fv = (g >= 0);
    m_fc = (g >= 0) ? g : 0;
    if (g >= 0) m_ptr = (g + 1) % NCH;
  endtask

  task automatic compare();
    int ef;
    int eo;
    ef = m_fv ? (1 << m_fc) : 0;
    eo = 0;
    for (int n = 0; n < NCH; n++) if (m_ovr[n]) eo |= (1 << n);
    chk("model_fire", int'(fire), ef);
    chk("model_fire_valid", int'(fire_valid), int'(m_fv));
    chk("model_fire_ch", int'(fire_ch), m_fc);
    chk("model_overrun", int'(overrun), eo);
    chk("model_tick_en", int'(tick_en), int'(m_te));
    if (fire_valid) fires_by_ch[fire_ch]++;
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    compare();
  endtask

  task automatic cfg_write(input int ch, input int p);
    cfg_we = 1'b1;
    cfg_ch = ch[1:0];
    cfg_period = p[7:0];
    step();
    cfg_we = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic clear_counts();
    for (int n = 0; n < NCH; n++) fires_by_ch[n] = 0;
  endtask

  initial begin
    int exp_seq [8];
    int r;
    clear_counts();

    // Reset held two cycles while base_tick and cfg_we toggle.
    reset = 1'b1; base_tick = 1'b1; cfg_we = 1'b1; cfg_ch = 2'd0; cfg_period = 8'd1;
    step();
    base_tick = 1'b0; cfg_we = 1'b0;
    step();
    chk("rst_fire", int'(fire), 0);
    chk("rst_fire_valid", int'(fire_valid), 0);
    chk("rst_fire_ch", int'(fire_ch), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_tick_en", int'(tick_en), 0);
    reset = 1'b0;
    step();

    // Ch0 period 3 with continuous base ticks.
    base_tick = 1'b1;
    cfg_write(0, 3);
    chk("p3_tick_en_lag", int'(tick_en), 0);
    clear_counts();
    for (int i = 0; i < 100; i++) begin
      step();
      if (i == 0) chk("p3_tick_en", int'(tick_en), 1);
      if (i == 2) chk("p3_no_early_fire", int'(fire), 0);
      if (i == 3) chk("p3_first_fire", int'(fire), 1);
      if (i == 6) chk("p3_second_fire", int'(fire), 1);
    end
    base_tick = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("p3_fire_count", fires_by_ch[0], 33);
    chk("p3_overrun", int'(overrun), 0);

    // Ch0 and ch1 period 2, sparse base ticks: simultaneous due.
    do_reset();
    cfg_write(0, 2);
    cfg_write(1, 2);
    base_tick = 1'b1; step(); base_tick = 1'b0;
    for (int i = 0; i < 9; i++) step();
    base_tick = 1'b1; step(); base_tick = 1'b0;
    chk("p2_not_yet", int'(fire_valid), 0);
    step();
    chk("p2_first_ch0", int'(fire), 1);
    step();
    chk("p2_then_ch1", int'(fire), 2);
    chk("p2_then_ch1_idx", int'(fire_ch), 1);
    step();
    chk("p2_idle", int'(fire_valid), 0);
    chk("p2_overrun", int'(overrun), 0);

    // All four channels period 1: round-robin saturation and overruns.
    do_reset();
    for (int n = 0; n < NCH; n++) cfg_write(n, 1);
    exp_seq = '{0, 1, 2, 3, 0, 1, 2, 3};
    base_tick = 1'b1;
    step();
    for (int k = 0; k < 8; k++) begin
      step();
      chk("rr_fire_ch", int'(fire_ch), exp_seq[k]);
      chk("rr_fire_valid", int'(fire_valid), 1);
    end
    chk("rr_overrun_all", int'(overrun), 15);
    ovr_clr = 1'b1; step(); ovr_clr = 1'b0;
    chk("rr_after_clr", $countones(overrun), 3);
    for (int k = 0; k < 4; k++) step();
    chk("rr_overrun_reset", int'(overrun), 15);
    base_tick = 1'b0;

    // Disable a pending channel before its grant.
    do_reset();
    cfg_write(0, 5);
    cfg_write(1, 5);
    cfg_write(2, 5);
    base_tick = 1'b1;
    for (int i = 0; i < 5; i++) step();
    base_tick = 1'b0;
    clear_counts();
    cfg_write(2, 0);
    chk("dis_grant_ch0", int'(fire), 1);
    cfg_write(0, 0);
    chk("dis_grant_ch1", int'(fire), 2);
    cfg_write(1, 0);
    chk("dis_tick_en_hold", int'(tick_en), 1);
    step();
    chk("dis_tick_en_fall", int'(tick_en), 0);
    for (int i = 0; i < 5; i++) step();
    chk("dis_no_ch2_fire", fires_by_ch[2], 0);

    // Reset while three channels are pending.
    do_reset();
    cfg_write(0, 1);
    cfg_write(1, 1);
    cfg_write(2, 1);
    base_tick = 1'b1;
    step();
    reset = 1'b1;
    step();
    chk("rstp_fire_valid", int'(fire_valid), 0);
    chk("rstp_tick_en", int'(tick_en), 0);
    reset = 1'b0;
    clear_counts();
    for (int i = 0; i < 10; i++) step();
    chk("rstp_no_fires", fires_by_ch[0] + fires_by_ch[1] + fires_by_ch[2], 0);
    chk("rstp_tick_en_end", int'(tick_en), 0);

    // Randomized traffic, checked every cycle against the model.
    for (int c = 0; c < 4000; c++) begin
      reset     = ($urandom_range(0, 299) == 0);
      base_tick = $urandom_range(0, 1) == 1;
      cfg_we    = ($urandom_range(0, 7) == 0);
      cfg_ch    = 2'($urandom_range(0, 3));
      r = $urandom_range(0, 9);
      if (r == 9) r = $urandom_range(1, 255);
      cfg_period = r[7:0];
      ovr_clr   = ($urandom_range(0, 15) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
